udp_lane_sequencer: RTL and testbench
=====================================

# udp_lane_sequencer

Time-multiplexes one narrow UDP evaluation slice (LANE_W `udp_not`-style lanes) across a wide input word. The full DATA_W result is built one lane group per cycle. A valid/ready request side feeds a sequencer FSM, which drives a valid/ready result side. The block sits in front of the wide-UDP datapath so that one primitive bank can serve arbitrarily wide operands.

## Interface

Parameters:
- DATA_W, 128, operand/result width; must be a multiple of LANE_W.
- LANE_W, 8, bits evaluated per cycle; NUM_STEPS = DATA_W/LANE_W.

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_data  input  DATA_W  operand.
- in_mode  input  1  0 = invert (udp_not), 1 = pass-through.
- flush  input  1  synchronous abort of the current job.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  DATA_W  result accumulator.
- busy  output  1  state != IDLE.
- jobs_done  output  16  count of completed output handshakes; wraps.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data and in_mode, clear the accumulator to 0, set step=0, go to RUN.
- RUN:
  - Each cycle, slice lanes [step*LANE_W +: LANE_W] of the latched operand through the eval unit.
  - Write the slice result into the same accumulator bits. LSB group first.
  - step increments each cycle.
  - When step==NUM_STEPS-1, go to DONE; step returns to 0.
- DONE:
  - out_valid=1. out_data is stable until out_ready.
  - On out_valid&&out_ready: jobs_done+=1 (mod 2^16), go to IDLE.
- Invert mode: out_data = ~in_data. Pass mode: out_data = in_data. Both are bitwise, with no width extension.
- in_ready=0 in RUN and DONE. A request is never accepted in the same cycle as an output handshake; in_ready rises the cycle after.
- flush has highest priority in any state:
  - Next state IDLE; accumulator cleared; step=0; out_valid drops.
  - jobs_done unchanged.
  - A simultaneous in_valid in IDLE is ignored.
- out_data outside DONE:
  - Shows the partial accumulator in RUN; lanes not yet processed are 0.
  - Consumers sample it only while out_valid=1.
- in_data and in_mode are don't-care after acceptance.

## Timing

- Reset values (asynchronous, rst_n low): state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, jobs_done=0, step=0, latched operand=0, mode=0.
- Acceptance edge T (in_valid&&in_ready sampled high).
- RUN occupies cycles T+1 … T+NUM_STEPS.
- out_valid is first high in cycle T+NUM_STEPS+1. Latency is NUM_STEPS+1 cycles (17 at defaults).
- Backpressure: out_valid is held indefinitely with out_data constant. No timeout.
- Throughput: one job per NUM_STEPS+2 cycles with out_ready tied high.
- rst_n asserted mid-job: immediate return to reset values. The job is lost.
- Deassertion of rst_n is synchronised externally.

## Structure

- Package udp_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the mode enum (MODE_INV=0, MODE_PASS=1);
  - the DATA_W/LANE_W defaults;
  - the jobs_done width constant (16).
- Sub-module udp_lane_eval: purely combinational, LANE_W lanes, inputs lane bits and mode, outputs lane result. Inversion is done by per-bit udp_not primitive instances, muxed against pass-through by mode. Its lanes are 2-state only, with no X/Z table rows.
- Top-level holds the FSM, step counter, operand/mode registers, accumulator, and jobs_done counter.

## Test plan

- Reset: rst_n low, then high → in_ready=1, out_valid=0, busy=0, out_data=0, jobs_done=0.
- in_data=0, mode=INV, out_ready=1 → out_valid first high 17 cycles after acceptance, out_data=all ones, jobs_done=1.
- in_data=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, mode=PASS, out_ready held low 5 cycles → out_data equals in_data and is stable for all 6 valid cycles; a single handshake occurs.
- flush pulsed at RUN step 7 → IDLE next cycle, out_valid never rises, jobs_done unchanged. A following INV job on 128'hFF produces ~128'hFF correctly.
- rst_n pulsed low at RUN step 3 → all outputs at reset values immediately. A new job is accepted after release and completes normally.
- Preload 0xFFFF jobs (or force the counter), then complete one job → jobs_done wraps to 0.

Source files
------------

// File: rtl/udp_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : udp_seq_pkg
// Brief  : Shared types and default sizes for the lane-sequenced UDP block.
// Rev    : 1.0  initial release
// ============================================================================
package udp_seq_pkg;

  localparam int c_DATA_W = 128;
  localparam int c_LANE_W = 8;
  localparam int c_JOBS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  typedef enum logic {
    MODE_INV  = 1'b0,
    MODE_PASS = 1'b1
  } seq_mode_e;

endpackage
`default_nettype wire

// File: rtl/udp_lane_eval.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : udp_lane_eval
// Brief  : Combinational LANE_W-wide evaluation slice (invert or pass-through).
// Rev    : 1.0  initial release
// ============================================================================
module udp_lane_eval
  import udp_seq_pkg::*;
#(
  parameter int LANE_W = c_LANE_W
) (
  input  logic [LANE_W-1:0] i_lane,
  input  seq_mode_e         i_mode,
  output logic [LANE_W-1:0] o_lane
);

  logic [LANE_W-1:0] w_inv;

  generate
    for (genvar i = 0; i < LANE_W; i++) begin : g_lane
      udp_not u_not (
        .i_a (i_lane[i]),
        .o_y (w_inv[i])
      );
    end
  endgenerate

  assign o_lane = (i_mode == MODE_PASS) ? i_lane : w_inv;

endmodule
`default_nettype wire

// File: rtl/udp_not.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : udp_not
// Brief  : Single-bit inverter cell with a two-state truth table.
// Rev    : 1.0  initial release
// ============================================================================
module udp_not (
  input  logic i_a,
  output logic o_y
);

  always_comb begin
    case (i_a)
      1'b0:    o_y = 1'b1;
      default: o_y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/udp_lane_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : udp_lane_sequencer
// Brief  : Sweeps one LANE_W eval slice across a DATA_W operand, LSB lane first.
// Rev    : 1.0  initial release
// ============================================================================
module udp_lane_sequencer
  import udp_seq_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int LANE_W = c_LANE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_mode,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                busy,
  output logic [c_JOBS_W-1:0] jobs_done
);

  localparam int                  c_NUM_STEPS = DATA_W / LANE_W;
  localparam int                  c_STEP_W    = (c_NUM_STEPS > 1) ? $clog2(c_NUM_STEPS) : 1;
  localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(c_NUM_STEPS - 1);

  seq_state_e          r_state;
  seq_state_e          w_state_nxt;
  logic [c_STEP_W-1:0] r_step;
  logic [DATA_W-1:0]   r_operand;
  logic [DATA_W-1:0]   r_acc;
  seq_mode_e           r_mode;
  logic [c_JOBS_W-1:0] r_jobs_done;
  logic [LANE_W-1:0]   w_lane_in;
  logic [LANE_W-1:0]   w_lane_out;
  logic                w_accept;
  logic                w_handshake;
  logic                w_last;
  int                  w_base;

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign out_data    = r_acc;
  assign jobs_done   = r_jobs_done;

  // flush outranks both handshakes so an aborted cycle neither accepts nor counts
  assign w_accept    = in_valid && in_ready && !flush;
  assign w_handshake = out_valid && out_ready && !flush;
  assign w_last      = (r_step == c_LAST_STEP);
  assign w_base      = int'(r_step) * LANE_W;
  assign w_lane_in   = r_operand[w_base +: LANE_W];

  udp_lane_eval #(
    .LANE_W (LANE_W)
  ) u_eval (
    .i_lane (w_lane_in),
    .i_mode (r_mode),
    .o_lane (w_lane_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid)  w_state_nxt = RUN;
        RUN:     if (w_last)    w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default:                w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step    <= '0;
      r_operand <= '0;
      r_mode    <= MODE_INV;
      r_acc     <= '0;
    end else if (flush) begin
      r_step <= '0;
      r_acc  <= '0;
    end else if (w_accept) begin
      r_operand <= in_data;
      r_mode    <= seq_mode_e'(in_mode);
      r_acc     <= '0;
      r_step    <= '0;
    end else if (r_state == RUN) begin
      r_acc[w_base +: LANE_W] <= w_lane_out;
      r_step                  <= w_last ? '0 : r_step + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_jobs_done <= '0;
    end else if (w_handshake) begin
      r_jobs_done <= r_jobs_done + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_lane_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_udp_lane_sequencer
// Brief  : Randomized self-checking bench with a lane-level reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_udp_lane_sequencer;

  localparam int DW     = 128;
  localparam int LW     = 8;
  localparam int NSTEPS = DW / LW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_mode   = 1'b0;
  logic          flush     = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [DW-1:0] out_data;
  logic [15:0]   jobs_done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_jobs = '0;

  always #5 clk = ~clk;

  udp_lane_sequencer #(
    .DATA_W (DW),
    .LANE_W (LW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .jobs_done (jobs_done)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] d, input logic m);
    return m ? d : ~d;
  endfunction

  function automatic logic [DW-1:0] low_mask(input int lanes);
    logic [DW-1:0] ones = '1;
    if (lanes <= 0) return '0;
    return ones >> (DW - lanes * LW);
  endfunction

  // Presents a request while idle; returns one cycle after the acceptance edge.
  task automatic start_job(input logic [DW-1:0] d, input logic m, input bit junk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    tick();
    in_valid = junk;
    in_data  = rand_word();
    in_mode  = $urandom_range(0, 1);
  endtask

  task automatic run_job(input logic [DW-1:0] d, input logic m, input int bp, input bit junk);
    logic [DW-1:0] exp;
    int            k;
    exp       = ref_result(d, m);
    out_ready = 1'b0;
    start_job(d, m, junk);
    k = 1;
    while (!out_valid && k <= NSTEPS + 4) begin
      check("busy_run", busy, 1);
      check("in_ready_run", in_ready, 0);
      check("partial", out_data, exp & low_mask(k - 1));
      tick();
      k++;
    end
    check("latency", k, NSTEPS + 1);
    check("result", out_data, exp);
    for (int i = 0; i < bp; i++) begin
      tick();
      check("valid_held", out_valid, 1);
      check("in_ready_done", in_ready, 0);
      check("result_stable", out_data, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    exp_jobs++;
    check("jobs_done", jobs_done, exp_jobs);
    check("valid_drop", out_valid, 0);
    check("in_ready_after", in_ready, 1);
    check("idle_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_jobs", jobs_done, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    run_job('0, 1'b0, 0, 1'b0);
    run_job(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 5, 1'b0);

    // abort mid-run, then try to sneak a request in alongside another flush
    start_job(rand_word(), 1'b0, 1'b0);
    repeat (7) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    check("flush_data", out_data, 0);
    check("flush_jobs", jobs_done, exp_jobs);
    in_valid = 1'b1;
    in_data  = rand_word();
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_ignores_req", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < NSTEPS + 4; i++) begin
      tick();
      seen |= out_valid;
    end
    check("flush_no_valid", seen, 0);
    run_job(128'hFF, 1'b0, 0, 1'b0);

    // asynchronous reset during RUN step 3
    start_job(rand_word(), 1'b1, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    exp_jobs = '0;
    check("arst_in_ready", in_ready, 1);
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_data", out_data, 0);
    check("arst_jobs", jobs_done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_job(rand_word(), 1'b0, 2, 1'b0);

    for (int j = 0; j < 6; j++) begin
      run_job(rand_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    force dut.r_jobs_done = 16'hFFFF;
    #1;
    release dut.r_jobs_done;
    exp_jobs = 16'hFFFF;
    run_job(rand_word(), 1'b1, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
